// File: rtl/background_pkg.sv
// Shared border draw codes and detector state encoding.
package background_pkg;
    localparam logic [1:0] BORDER_NONE = 2'b00;
    localparam logic [1:0] BORDER_MOVE = 2'b01;
    localparam logic [1:0] BORDER_ZONE = 2'b10;

    typedef enum logic {
        WAIT_SOF = 1'b0,
        ACCUM    = 1'b1
    } det_state_t;
endpackage

// File: rtl/border_hit_latch.sv
// Per-object sticky hit flags, reported and reloaded at each frame boundary.
// BORDER_HIT_EDGE_EN: report only contact onset against the previously reported frame.
module border_hit_latch (
    input  logic clk,
    input  logic resetN,
    input  logic accum_en,
    input  logic sof,
    input  logic hit_move,
    input  logic hit_zone,
    output logic rep_move,
    output logic rep_zone,
    output logic rep_move_next
);
    logic move_acc_q, move_acc_d;
    logic zone_acc_q, zone_acc_d;
    logic rep_move_q, rep_move_d;
    logic rep_zone_q, rep_zone_d;
`ifdef BORDER_HIT_EDGE_EN
    logic move_prev_q, move_prev_d;
    logic zone_prev_q, zone_prev_d;
`endif

    always_comb begin
        move_acc_d = move_acc_q | hit_move;
        zone_acc_d = zone_acc_q | hit_zone;
        rep_move_d = 1'b0;
        rep_zone_d = 1'b0;
`ifdef BORDER_HIT_EDGE_EN
        move_prev_d = move_prev_q;
        zone_prev_d = zone_prev_q;
`endif
        if (sof) begin
            // The strobe pixel belongs to the frame that is starting.
            move_acc_d = hit_move;
            zone_acc_d = hit_zone;
            if (accum_en) begin
`ifdef BORDER_HIT_EDGE_EN
                rep_move_d  = move_acc_q & ~move_prev_q;
                rep_zone_d  = zone_acc_q & ~zone_prev_q;
                move_prev_d = move_acc_q;
                zone_prev_d = zone_acc_q;
`else
                rep_move_d = move_acc_q;
                rep_zone_d = zone_acc_q;
`endif
            end
        end else if (!accum_en) begin
            move_acc_d = 1'b0;
            zone_acc_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            move_acc_q  <= 1'b0;
            zone_acc_q  <= 1'b0;
            rep_move_q  <= 1'b0;
            rep_zone_q  <= 1'b0;
`ifdef BORDER_HIT_EDGE_EN
            move_prev_q <= 1'b0;
            zone_prev_q <= 1'b0;
`endif
        end else begin
            move_acc_q  <= move_acc_d;
            zone_acc_q  <= zone_acc_d;
            rep_move_q  <= rep_move_d;
            rep_zone_q  <= rep_zone_d;
`ifdef BORDER_HIT_EDGE_EN
            move_prev_q <= move_prev_d;
            zone_prev_q <= zone_prev_d;
`endif
        end
    end

    assign rep_move      = rep_move_q;
    assign rep_zone      = rep_zone_q;
    assign rep_move_next = rep_move_d;
endmodule

// File: rtl/border_collision_detector.sv
// Frame-level border collision reporting for NUM_OBJECTS objects.
// Optional BORDER_HIT_EDGE_EN switches reports from level to contact onset.
module border_collision_detector
    import background_pkg::*;
#(
    parameter int NUM_OBJECTS = 4,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic                   startOfFrame,
    input  logic [1:0]             bordersDR,
    input  logic [NUM_OBJECTS-1:0] objectDR,
    output logic [NUM_OBJECTS-1:0] hitMoveBorder,
    output logic [NUM_OBJECTS-1:0] hitZoneLine,
    output logic [COUNT_WIDTH-1:0] hitFrameCount,
    output det_state_t             dbg_state
);
    det_state_t             state_q, state_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [NUM_OBJECTS-1:0] move_next;
    logic                   on_move, on_zone;

    assign on_move = (bordersDR & BORDER_MOVE) != BORDER_NONE;
    assign on_zone = (bordersDR & BORDER_ZONE) != BORDER_NONE;

    always_comb begin
        state_d = state_q;
        if (state_q == WAIT_SOF && startOfFrame) state_d = ACCUM;
    end

    // Count advances on the same edge the report becomes visible.
    always_comb begin
        count_d = count_q;
        if (|move_next && count_q != {COUNT_WIDTH{1'b1}}) count_d = count_q + COUNT_WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q <= WAIT_SOF;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    for (genvar i = 0; i < NUM_OBJECTS; i++) begin : g_obj
        border_hit_latch u_latch (
            .clk          (clk),
            .resetN       (resetN),
            .accum_en     (state_q == ACCUM),
            .sof          (startOfFrame),
            .hit_move     (objectDR[i] & on_move),
            .hit_zone     (objectDR[i] & on_zone),
            .rep_move     (hitMoveBorder[i]),
            .rep_zone     (hitZoneLine[i]),
            .rep_move_next(move_next[i])
        );
    end

    assign hitFrameCount = count_q;
    assign dbg_state     = state_q;
endmodule
